// File: rtl/mul4x3_sched.sv
// Round-robin scheduler sharing one combinational 4x3 multiplier among NREQ requesters.
// Winner's operands are captured, multiplied, and the product is returned with its id.
module bit4_3_mul (
  input  logic [2:0] a_i,
  input  logic [3:0] b_i,
  output logic [6:0] c_o
);
  assign c_o = {4'b0, a_i} * {3'b0, b_i};
endmodule

module mul4x3_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [6:0]        res_data,
  output logic [IDW-1:0]    res_id
);
  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, pick;
  logic [2:0]     op_a_q;
  logic [3:0]     op_b_q;
  logic [6:0]     prod;
  logic [6:0]     res_data_q;
  logic [IDW-1:0] res_id_q;
  logic           found;
  int             idx;

  // First requester above the previous winner, wrapping around.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state_q == GRANT) grant[last_q] = 1'b1;
    busy      = (state_q != IDLE);
    res_valid = (state_q == RESP);
    res_data  = res_data_q;
    res_id    = res_id_q;
  end

  bit4_3_mul u_mul (.a_i(op_a_q), .b_i(op_b_q), .c_o(prod));

  // last_q doubles as the current winner from GRANT through EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= IDW'(NREQ - 1);
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      if (state_q == IDLE && |req) last_q <= pick;
      if (state_q == GRANT) begin
        op_a_q <= a_in[3*int'(last_q) +: 3];
        op_b_q <= b_in[4*int'(last_q) +: 4];
      end
      if (state_q == EXEC) begin
        res_data_q <= prod;
        res_id_q   <= last_q;
      end
    end
  end
endmodule

// File: tb/tb_mul4x3_sched.sv
// Bench for mul4x3_sched: directed scenarios plus randomized traffic against a round-robin model.
module tb_mul4x3_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [3:0]  grant;
  logic        busy, res_valid;
  logic        res_ready = 1'b1;
  logic [6:0]  res_data;
  logic [1:0]  res_id;

  int errs = 0, checks = 0, cyc = 0, m_last = 3;
  logic [2:0] ta [4];
  logic [3:0] tb [4];

  mul4x3_sched #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .grant(grant),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic pack();
    for (int i = 0; i < 4; i++) begin
      a_in[3*i +: 3] = ta[i];
      b_in[4*i +: 4] = tb[i];
    end
  endtask

  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int k = 1; k <= 4; k++)
      if (p[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic int prod(input int i);
    return int'(ta[i]) * int'(tb[i]);
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; res_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; m_last = 3;
  endtask

  // Waits (bounded) for a grant and then for the result; no checking here.
  task automatic serve(input bit drop, output logic [3:0] gv, output int gidx, output int gcyc,
                       output int vcyc, output logic [6:0] d, output logic [1:0] id, output bit to);
    to = 0; gidx = -1; gv = '0; gcyc = 0; vcyc = -1; d = '0; id = '0;
    for (int k = 0; k < 30 && gidx < 0; k++) begin
      tick();
      if (grant != 0) begin
        gv = grant; gcyc = cyc;
        for (int i = 3; i >= 0; i--) if (grant[i]) gidx = i;
      end
    end
    if (gidx < 0) begin to = 1; return; end
    if (drop) req[gidx] = 1'b0;
    for (int k = 0; k < 30 && vcyc < 0; k++) begin
      tick();
      if (res_valid) begin vcyc = cyc; d = res_data; id = res_id; end
    end
    if (vcyc < 0) to = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; #3;
    checks++; if (grant !== 4'b0) begin errs++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 7'd0) begin errs++; $display("FAIL reset_data got=%0d exp=0", res_data); end
    checks++; if (res_id !== 2'd0) begin errs++; $display("FAIL reset_id got=%0d exp=0", res_id); end
    do_reset();
  endtask

  task automatic test_single();
    ta[0] = 3'd3; tb[0] = 4'd6; pack(); req = 4'b0001;
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errs++; $display("FAIL single_c0 grant=%b busy=%b exp 0000/0", grant, busy); end
    tick();
    checks++; if (grant !== 4'b0001) begin errs++; $display("FAIL single_grant got=%b exp=0001", grant); end
    req = '0;
    tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL single_exec valid=%b busy=%b exp 0/1", res_valid, busy); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 7'd18 || res_id !== 2'd0) begin
      errs++; $display("FAIL single_resp valid=%b data=%0d id=%0d exp 1/18/0", res_valid, res_data, res_id); end
    tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL single_idle valid=%b busy=%b exp 0/0", res_valid, busy); end
    m_last = 0;
  endtask

  task automatic test_exhaustive();
    logic [3:0] gv; int gi, gc, vc; logic [6:0] d; logic [1:0] id; bit to;
    for (int a = 0; a < 8; a++) for (int b = 0; b < 16; b++) begin
      ta[2] = 3'(a); tb[2] = 4'(b); pack(); req = 4'b0100;
      serve(1'b1, gv, gi, gc, vc, d, id, to);
      checks++;
      if (to || gv !== 4'b0100 || id !== 2'd2 || int'(d) != a * b || vc - gc != 2) begin
        errs++; $display("FAIL exh a=%0d b=%0d grant=%b id=%0d data=%0d lat=%0d exp 0100/2/%0d/2 to=%0d",
                         a, b, gv, id, d, vc - gc, a * b, to);
      end
      m_last = 2;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] gv; int gi, gc, vc, prev, ex; logic [6:0] d; logic [1:0] id; bit to;
    do_reset();
    for (int i = 0; i < 4; i++) begin ta[i] = 3'(i + 4); tb[i] = 4'(15 - 2*i); end
    pack(); req = 4'b1111; prev = 0;
    for (int n = 0; n < 6; n++) begin
      ex = rr_pick(4'b1111, m_last);
      serve(1'b0, gv, gi, gc, vc, d, id, to);
      checks++;
      if (to || ex != n % 4 || gv !== 4'(1 << ex) || id !== 2'(ex) || int'(d) != prod(ex)) begin
        errs++; $display("FAIL fair n=%0d grant=%b id=%0d data=%0d exp idx=%0d data=%0d to=%0d",
                         n, gv, id, d, n % 4, prod(n % 4), to);
      end
      if (n > 0) begin
        checks++; if (gc - prev != 4) begin errs++; $display("FAIL fair_interval got=%0d exp=4", gc - prev); end
      end
      prev = gc; m_last = ex;
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    logic [6:0] d0;
    do_reset();
    for (int i = 0; i < 4; i++) begin ta[i] = 3'($urandom_range(7)); tb[i] = 4'($urandom_range(15)); end
    pack(); req = 4'b1010; res_ready = 1'b0;
    tick();
    checks++; if (grant !== 4'b0010) begin errs++; $display("FAIL bp_grant1 got=%b exp=0010", grant); end
    tick(); tick();
    d0 = res_data;
    checks++; if (res_valid !== 1'b1 || int'(res_data) != prod(1) || res_id !== 2'd1) begin
      errs++; $display("FAIL bp_resp valid=%b data=%0d id=%0d exp 1/%0d/1", res_valid, res_data, res_id, prod(1)); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== d0 || grant !== 4'b0) begin
        errs++; $display("FAIL bp_hold k=%0d valid=%b data=%0d grant=%b exp 1/%0d/0000", k, res_valid, res_data, grant, d0); end
    end
    res_ready = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0 || grant !== 4'b0) begin errs++; $display("FAIL bp_idle valid=%b grant=%b exp 0/0000", res_valid, grant); end
    tick();
    checks++; if (grant !== 4'(1 << rr_pick(4'b1010, 1))) begin errs++; $display("FAIL bp_grant2 got=%b exp=1000", grant); end
    req = '0;
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || int'(res_data) != prod(3) || res_id !== 2'd3) begin
      errs++; $display("FAIL bp_resp2 valid=%b data=%0d id=%0d exp 1/%0d/3", res_valid, res_data, res_id, prod(3)); end
    tick();
    m_last = 3;
  endtask

  task automatic test_mid_reset();
    do_reset();
    ta[1] = 3'd5; tb[1] = 4'd9; ta[0] = 3'd7; tb[0] = 4'd15; pack(); req = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errs++; $display("FAIL mr_grant got=%b exp=0010", grant); end
    req = '0;
    tick();
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL mr_exec busy=%b exp=1", busy); end
    #2 rst = 1'b1; #1;
    checks++; if (grant !== 4'b0 || busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 7'd0 || res_id !== 2'd0) begin
      errs++; $display("FAIL mr_async grant=%b busy=%b valid=%b data=%0d id=%0d exp all 0", grant, busy, res_valid, res_data, res_id); end
    tick(); tick();
    checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL mr_novalid got=%b exp=0", res_valid); end
    rst = 1'b0; m_last = 3; req = 4'b1001;
    tick();
    checks++; if (grant !== 4'b0001) begin errs++; $display("FAIL mr_regrant got=%b exp=0001", grant); end
    req = 4'b1000;
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 7'd105 || res_id !== 2'd0) begin
      errs++; $display("FAIL mr_resp valid=%b data=%0d id=%0d exp 1/105/0", res_valid, res_data, res_id); end
    req = '0; m_last = 0;
    tick();
  endtask

  task automatic test_withdraw();
    logic [3:0] gv; int gi, gc, vc; logic [6:0] d; logic [1:0] id; bit to;
    ta[1] = 3'd6; tb[1] = 4'd11; pack(); req = 4'b0010;
    serve(1'b1, gv, gi, gc, vc, d, id, to);
    checks++; if (to || gv !== 4'b0010 || id !== 2'd1 || d !== 7'd66) begin
      errs++; $display("FAIL withdraw grant=%b id=%0d data=%0d exp 0010/1/66 to=%0d", gv, id, d, to); end
    m_last = 1;
  endtask

  task automatic test_random();
    logic [3:0] gv, pend; int gi, gc, vc, ex; logic [6:0] d; logic [1:0] id; bit to;
    pend = '0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i] = 1'b1; ta[i] = 3'($urandom_range(7)); tb[i] = 4'($urandom_range(15));
        end
      if (pend == 0) begin pend[0] = 1'b1; ta[0] = 3'($urandom_range(7)); tb[0] = 4'($urandom_range(15)); end
      pack(); req = pend;
      ex = rr_pick(pend, m_last);
      serve(1'b1, gv, gi, gc, vc, d, id, to);
      checks++;
      if (to || gv !== 4'(1 << ex) || id !== 2'(ex) || int'(d) != prod(ex)) begin
        errs++; $display("FAIL rand n=%0d pend=%b grant=%b id=%0d data=%0d exp idx=%0d data=%0d to=%0d",
                         n, pend, gv, id, d, ex, prod(ex), to);
      end
      pend[ex] = 1'b0; m_last = ex;
    end
    req = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin ta[i] = '0; tb[i] = '0; end
    test_reset();
    test_single();
    test_exhaustive();
    test_fairness();
    test_backpressure();
    test_mid_reset();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
